sram_ctrl: RTL

Sits directly downstream of the MEM stage and drives one external 32-bit asynchronous SRAM bank.
- Consumes the MEM stage's ce/we/sel/addr/data request.
- Runs a multi-cycle SRAM read or write.
- Returns read data with a level-held ready that the MEM stage uses to advance its cnt-based multi-clock sequence.
- Single master; no arbitration with instruction fetch.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_ctrl_if.sv | 20 ++
 rtl/sram_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    SRAM_IDLE  = 3'd0,
    SRAM_READ  = 3'd1,
    SRAM_WRITE = 3'd2,
    SRAM_WHOLD = 3'd3,
    SRAM_DONE  = 3'd4
  } sram_state_e;

  localparam logic       SRAM_DISABLE = 1'b1;
  localparam logic [3:0] SRAM_BE_NONE = 4'b1111;

  // Width of a down-counter that must hold max(rd, wr) - 1.
  function automatic int unsigned cnt_width(input int unsigned rd, input int unsigned wr);
    int unsigned m;
    m = (rd > wr) ? rd : wr;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline and the SRAM controller.
interface sram_ctrl_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  mem_data_o, mem_ready_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output mem_data_o, mem_ready_o
  );
endinterface

// File: rtl/sram_ctrl.sv
// Multi-cycle controller for one 32-bit asynchronous SRAM bank behind the MEM stage.
// All SRAM pins come straight from flops so the strobes are glitch-free.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        mem,
  output logic [ADDR_W-1:0] sram_addr_o,
  inout  wire  [31:0]       sram_data_io,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam int CNT_W = cnt_width(RD_WAIT, WR_WAIT);

  sram_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              drv_q, drv_d;

  // Byte offset and bits above the bank are deliberately dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem.mem_addr_i[31:ADDR_W+2], mem.mem_addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      SRAM_IDLE: begin
        if (mem.mem_ce_i) begin
          addr_d  = mem.mem_addr_i[ADDR_W+1:2];
          sel_d   = mem.mem_sel_i;
          wdata_d = mem.mem_data_i;
          if (mem.mem_we_i) begin
            state_d = SRAM_WRITE;
            cnt_d   = CNT_W'(WR_WAIT - 1);
          end else begin
            state_d = SRAM_READ;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      SRAM_READ: begin
        // Dropping ce aborts a read without touching the returned data.
        if (!mem.mem_ce_i) begin
          state_d = SRAM_IDLE;
        end else if (cnt_q == '0) begin
          rdata_d = sram_data_io;
          state_d = SRAM_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SRAM_WRITE: begin
        if (cnt_q == '0) state_d = SRAM_WHOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SRAM_WHOLD: state_d = SRAM_DONE;
      SRAM_DONE:  if (!mem.mem_ce_i) state_d = SRAM_IDLE;
      default:    state_d = SRAM_IDLE;
    endcase

    // Pin levels are decoded from the next state so they line up with it.
    ce_n_d  = SRAM_DISABLE;
    oe_n_d  = SRAM_DISABLE;
    we_n_d  = SRAM_DISABLE;
    be_n_d  = SRAM_BE_NONE;
    drv_d   = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      SRAM_READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = ~sel_d;
      end
      SRAM_WRITE: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        be_n_d = ~sel_d;
        drv_d  = 1'b1;
      end
      SRAM_WHOLD: begin
        ce_n_d = 1'b0;
        be_n_d = ~sel_d;
        drv_d  = 1'b1;
      end
      SRAM_DONE: ready_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SRAM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      ce_n_q  <= SRAM_DISABLE;
      oe_n_q  <= SRAM_DISABLE;
      we_n_q  <= SRAM_DISABLE;
      be_n_q  <= SRAM_BE_NONE;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      drv_q   <= drv_d;
    end
  end

  // Holding registers for write payload; only meaningful once a request is latched.
  always_ff @(posedge clk) begin
    sel_q   <= sel_d;
    wdata_q <= wdata_d;
  end

  assign sram_data_io    = drv_q ? wdata_q : 32'hzzzz_zzzz;
  assign sram_addr_o     = addr_q;
  assign sram_ce_n_o     = ce_n_q;
  assign sram_oe_n_o     = oe_n_q;
  assign sram_we_n_o     = we_n_q;
  assign sram_be_n_o     = be_n_q;
  assign mem.mem_data_o  = rdata_q;
  assign mem.mem_ready_o = ready_q;

endmodule
